// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-cache and D-cache line transactions onto one memory port,
// breaking simultaneous requests round-robin and stalling the loser by withholding its ready.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_read,
    input  logic              ic_write,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [DATA_W-1:0] ic_wdata,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        arb_grant
);
    typedef enum logic [1:0] {IDLE, SERVE_IC, SERVE_DC} state_t;
    state_t            state_q, state_d;
    logic              last_dc_q, last_dc_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        grant_q, grant_d;
    logic              ic_req, dc_req, pick_dc;
    assign ic_req  = ic_read | ic_write;
    assign dc_req  = dc_read | dc_write;
    // On a tie the side that did not win last time goes next.
    assign pick_dc = dc_req & (~ic_req | ~last_dc_q);
    always_comb begin
        state_d     = state_q;
        last_dc_d   = last_dc_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = grant_q;
        if (state_q == IDLE && (ic_req || dc_req)) begin
            state_d     = pick_dc ? SERVE_DC : SERVE_IC;
            last_dc_d   = pick_dc;
            mem_write_d = pick_dc ? dc_write : ic_write;
            mem_read_d  = pick_dc ? (dc_read & ~dc_write) : (ic_read & ~ic_write);
            mem_addr_d  = pick_dc ? dc_addr : ic_addr;
            mem_wdata_d = pick_dc ? dc_wdata : ic_wdata;
            grant_d     = pick_dc ? 2'b10 : 2'b01;
        end else if (state_q != IDLE && mem_ready) begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            grant_d     = 2'b00;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_dc_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            last_dc_q   <= last_dc_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_q     <= grant_d;
        end
    end
    assign ic_ready  = (state_q == SERVE_IC) & mem_ready;
    assign dc_ready  = (state_q == SERVE_DC) & mem_ready;
    assign ic_rdata  = mem_rdata;
    assign dc_rdata  = mem_rdata;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign arb_grant = grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and memory against a transaction-level arbitration model,
// with a negedge monitor scoring issued memory transactions and cache readies from expectation queues.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 0, rst_n = 0;
    logic          ic_read = 0, ic_write = 0, dc_read = 0, dc_write = 0, mem_ready = 0;
    logic [AW-1:0] ic_addr = '0, dc_addr = '0;
    logic [DW-1:0] ic_wdata = '0, dc_wdata = '0, mem_rdata = '0;
    logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          ic_ready, dc_ready, mem_read, mem_write;
    logic [1:0]    arb_grant;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_read(ic_read), .ic_write(ic_write), .ic_addr(ic_addr), .ic_wdata(ic_wdata),
        .ic_rdata(ic_rdata), .ic_ready(ic_ready),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ready(dc_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_grant(arb_grant)
    );

    typedef struct {logic [1:0] side; logic rd; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;} mem_t;
    typedef struct {logic [1:0] side; logic [DW-1:0] data;} rdy_t;
    mem_t       exp_mem[$];
    rdy_t       exp_rdy[$];
    logic [1:0] glog[$];

    int checks = 0, passes = 0, n_done = 0, lat = 0, next_lat = 0;
    bit busy = 0, last_dc = 0, rst_edge = 0, use_rdata = 0;
    bit spur_en = 0, force_spur = 0, auto_en = 0, chg_en = 0, persist_ic = 0, persist_dc = 0;
    bit ic_done = 0, dc_done = 0;
    logic [DW-1:0] next_rdata = '0;
    mem_t cur;

    task automatic ck(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] glog4();
        logic [7:0] v = '0;
        for (int i = 0; i < 4; i++) if (i < glog.size()) v[7-2*i -: 2] = glog[i];
        return v;
    endfunction

    task automatic new_ic();
        ic_read  = ($urandom_range(0, 7) != 0);
        ic_write = !ic_read;
        ic_addr  = AW'($urandom());
        ic_wdata = rand128();
    endtask

    task automatic new_dc();
        int k;
        k = $urandom_range(0, 2);
        dc_read  = (k != 1);
        dc_write = (k != 0);
        dc_addr  = AW'($urandom());
        dc_wdata = rand128();
    endtask

    // One clock: the model consumes what was presented at the edge, then the memory and requesters react.
    task automatic step();
        bit ic_r, dc_r, pdc;
        @(posedge clk);
        rst_edge = !rst_n;
        ic_r = ic_read | ic_write;
        dc_r = dc_read | dc_write;
        if (!rst_n) begin
            busy = 0; last_dc = 0; lat = 0;
        end else if (busy) begin
            if (mem_ready) begin busy = 0; n_done++; end
        end else if (ic_r || dc_r) begin
            pdc        = dc_r && (!ic_r || !last_dc);
            cur.side   = pdc ? 2'b10 : 2'b01;
            cur.wr     = pdc ? dc_write : ic_write;
            cur.rd     = !cur.wr;
            cur.addr   = pdc ? dc_addr : ic_addr;
            cur.wdata  = pdc ? dc_wdata : ic_wdata;
            exp_mem.push_back(cur);
            last_dc    = pdc;
            busy       = 1;
            lat        = (next_lat > 0) ? next_lat : $urandom_range(1, 5);
            next_lat   = 0;
        end
        #1;
        mem_ready = 0;
        if (busy) begin
            lat--;
            if (lat == 0) begin
                mem_ready = 1;
                mem_rdata = use_rdata ? next_rdata : rand128();
                use_rdata = 0;
                exp_rdy.push_back('{cur.side, mem_rdata});
            end
        end else if (force_spur || (spur_en && $urandom_range(0, 3) == 0)) begin
            mem_ready  = 1;
            mem_rdata  = rand128();
            force_spur = 0;
        end
        if (ic_done) begin
            ic_done = 0; ic_read = 0; ic_write = 0;
            if (persist_ic) new_ic();
        end else if ((ic_read | ic_write) && chg_en && $urandom_range(0, 3) == 0) begin
            ic_addr = AW'($urandom()); ic_wdata = rand128();
        end
        if (dc_done) begin
            dc_done = 0; dc_read = 0; dc_write = 0;
            if (persist_dc) new_dc();
        end else if ((dc_read | dc_write) && chg_en && $urandom_range(0, 3) == 0) begin
            dc_addr = AW'($urandom()); dc_wdata = rand128();
        end
        if (!(ic_read | ic_write) && auto_en && $urandom_range(0, 2) == 0) new_ic();
        if (!(dc_read | dc_write) && auto_en && $urandom_range(0, 2) == 0) new_dc();
    endtask

    task automatic drain();
        auto_en = 0; persist_ic = 0; persist_dc = 0;
        for (int i = 0; i < 300 && (ic_read | ic_write | dc_read | dc_write | busy); i++) step();
        ck("drain_timeout", DW'({ic_read, ic_write, dc_read, dc_write, busy}), '0);
    endtask

    logic [1:0]    prev_grant = 2'b00, h_grant;
    logic          h_rd, h_wr;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;

    always @(negedge clk) begin
        mem_t e;
        rdy_t r;
        ck("rw_exclusive", DW'(mem_read & mem_write), '0);
        ck("ready_exclusive", DW'(ic_ready & dc_ready), '0);
        if (rst_edge) begin
            ck("reset_ctrl", DW'({mem_read, mem_write, arb_grant, ic_ready, dc_ready}), '0);
            ck("reset_addr", DW'(mem_addr), '0);
            ck("reset_wdata", mem_wdata, '0);
        end
        if (arb_grant != 2'b00 && prev_grant == 2'b00) begin
            glog.push_back(arb_grant);
            if (exp_mem.size() == 0) ck("issue_expected", DW'(arb_grant), '0);
            else begin
                e = exp_mem.pop_front();
                ck("grant", DW'(arb_grant), DW'(e.side));
                ck("mem_read", DW'(mem_read), DW'(e.rd));
                ck("mem_write", DW'(mem_write), DW'(e.wr));
                ck("mem_addr", DW'(mem_addr), DW'(e.addr));
                ck("mem_wdata", mem_wdata, e.wdata);
            end
            h_grant = arb_grant; h_rd = mem_read; h_wr = mem_write; h_addr = mem_addr; h_wdata = mem_wdata;
        end else if (arb_grant != 2'b00) begin
            ck("hold_ctrl", DW'({arb_grant, mem_read, mem_write, mem_addr}), DW'({h_grant, h_rd, h_wr, h_addr}));
            ck("hold_wdata", mem_wdata, h_wdata);
        end else begin
            ck("idle_strobes", DW'({mem_read, mem_write}), '0);
        end
        if (ic_ready || dc_ready) begin
            if (exp_rdy.size() == 0) ck("ready_expected", DW'({dc_ready, ic_ready}), '0);
            else begin
                r = exp_rdy.pop_front();
                ck("ready_side", DW'({dc_ready, ic_ready}), DW'(r.side));
                ck("rdata", ic_ready ? ic_rdata : dc_rdata, r.data);
            end
            if (ic_ready) ic_done = 1;
            if (dc_ready) dc_done = 1;
        end
        prev_grant = arb_grant;
    end

    initial begin
        int d0;
        rst_n = 0;
        repeat (3) step();
        rst_n = 1;
        glog.delete();
        ic_read = 1; ic_addr = 28'h0000010; ic_wdata = '0;
        dc_write = 1; dc_addr = 28'h0000200; dc_wdata = {4{32'h12345678}};
        drain();
        ck("first_tie_order", DW'(glog4()), DW'(8'b10_01_00_00));

        glog.delete();
        persist_ic = 1; persist_dc = 1;
        new_ic(); new_dc();
        d0 = n_done;
        for (int i = 0; i < 200 && n_done < d0 + 4; i++) step();
        drain();
        ck("sustained_alternation", DW'(glog4()), DW'(8'b10_01_10_01));

        dc_read = 1; dc_write = 1; dc_addr = AW'($urandom()); dc_wdata = rand128();
        drain();

        auto_en = 1; spur_en = 1; chg_en = 1;
        repeat (1500) step();
        drain();
        spur_en = 0; chg_en = 0;

        rst_n = 0; step(); rst_n = 1; step();
        next_lat = 4; use_rdata = 1; next_rdata = {16{8'hA5}};
        ic_read = 1; ic_addr = 28'h0000010;
        drain();

        next_lat = 20; ic_read = 1; ic_addr = AW'($urandom());
        repeat (3) step();
        rst_n = 0; ic_read = 0;
        step();
        rst_n = 1; force_spur = 1;
        step(); step();
        drain();

        ck("exp_mem_left", DW'(exp_mem.size()), '0);
        ck("exp_rdy_left", DW'(exp_rdy.size()), '0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache miss/refill path and the D-cache miss/write-back path.
- Sits between the two cache controllers and the memory model.
- A 3-state FSM serialises transactions and breaks ties between simultaneous requesters round-robin.
- Blocks the losing requester by withholding its ready, so the pipeline's cache-stall logic holds the pipeline with no extra hazard signalling.

Parameters:
- ADDR_W, 28, memory block address width (word address >> 2)
- DATA_W, 128, cache line width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- ic_read  input  1  I-cache line read request; level-held until ic_ready
- ic_write  input  1  I-cache write request; always 0 in this design, handled generically
- ic_addr  input  ADDR_W  I-cache block address
- ic_wdata  input  DATA_W  I-cache write line
- ic_rdata  output  DATA_W  read line to I-cache
- ic_ready  output  1  transaction complete for I-cache, one-cycle pulse
- dc_read  input  1  D-cache line read request
- dc_write  input  1  D-cache write-back request
- dc_addr  input  ADDR_W  D-cache block address
- dc_wdata  input  DATA_W  D-cache write-back line
- dc_rdata  output  DATA_W  read line to D-cache
- dc_ready  output  1  transaction complete for D-cache, one-cycle pulse
- mem_read  output  1  memory read strobe, registered
- mem_write  output  1  memory write strobe, registered
- mem_addr  output  ADDR_W  registered memory address
- mem_wdata  output  DATA_W  registered memory write line
- mem_rdata  input  DATA_W  memory read line, valid when mem_ready=1
- mem_ready  input  1  memory completion, one cycle, arbitrary latency >=1
- arb_grant  output  2  current owner: 00 none, 01 I-cache, 10 D-cache

Behaviour:
- Reset (rst_n=0 at rising edge):
  - state=IDLE; mem_read, mem_write, mem_addr, mem_wdata = 0.
  - arb_grant=00; last_grant=ICACHE.
  - ic_ready=dc_ready=0.
  - Reset mid-transaction abandons it; no ready is issued for it.
- States: IDLE, SERVE_IC, SERVE_DC.
- Request per side: req_x = x_read | x_write. If both are high, the write is issued and the read is ignored; a requester may not do this.
- IDLE:
  - Only ic requests -> SERVE_IC. Only dc requests -> SERVE_DC.
  - Both request -> grant the side not equal to last_grant. After reset, D-cache wins the first tie.
  - On the granting edge: register mem_addr/mem_wdata from the winner; mem_read/mem_write from the winner's strobes; update last_grant; set arb_grant.
  - Request latency is therefore 1 cycle from req to mem strobe.
- SERVE_x:
  - Hold all mem_* outputs stable; ignore changes on requester inputs.
  - On the cycle mem_ready=1: x_ready=1 combinationally (same cycle), x_rdata=mem_rdata.
  - Next edge: state=IDLE, mem_read=mem_write=0, arb_grant=00.
- Requester contract: it deasserts or changes its request on the edge where it samples ready.
- Round trip:
  - Minimum one IDLE cycle between back-to-back transactions; no back-to-back issue from SERVE.
  - Worst-case wait for a loser = one full transaction of the other side plus one cycle.
- Readies: ic_ready/dc_ready are never both 1; never 1 outside SERVE; never asserted for the non-granted side.
- rdata:
  - ic_rdata and dc_rdata are driven with mem_rdata at all times; only ready qualifies them.
  - mem_rdata is sampled only via ready; its value otherwise is don't-care.
- mem_ready while IDLE: ignored, no ready issued.
- Memory protocol: mem_read and mem_write never both 1.
- Widths: no address arithmetic; pure pass-through of ADDR_W/DATA_W fields.

Test Plan:
- Single I-fetch miss: ic_read=1, ic_addr=0x0000010, mem_ready after 4 cycles with mem_rdata=0xA5..A5.
  -> mem_read=1, mem_addr=0x0000010 one cycle after request; ic_ready=1 with ic_rdata=0xA5..A5 same cycle as mem_ready; arb_grant 01 then 00.
- Simultaneous first contention after reset: ic_read=1 and dc_write=1 (dc_addr=0x0000200, dc_wdata=0x1234..) in the same cycle.
  -> D-cache served first: mem_write=1 with dc data; after dc_ready, one IDLE cycle, then mem_read for the I-cache.
- Sustained contention, both requesting continuously for 4 transactions.
  -> grants alternate DC, IC, DC, IC; no side starves.
- Write priority: dc_read=1 and dc_write=1 together.
  -> mem_write=1, mem_read=0.
- Spurious memory response and input stability:
  - mem_ready=1 pulse while IDLE -> no ic_ready/dc_ready.
  - dc_addr changed mid-SERVE_DC -> mem_addr unchanged.
- Reset mid-transaction: rst_n=0 during SERVE_IC with mem_ready pending.
  -> next cycle all outputs 0, arb_grant=00; a later mem_ready produces no ready.
